// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, data width and parity helper.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  // Even parity of the data word, inverted for odd parity.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1, held at 0 while clear is high.
module uart_baud_cnt #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_done,
  output logic bit_pre_done
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] PRE  = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] cnt_q;

  // Count within the bit period, wrapping on terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear || (cnt_q == TERM)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Decodes of the counter register; pre_done lets callers register strobes that land on bit_done.
  assign bit_done     = !clear && (cnt_q == TERM);
  assign bit_pre_done = !clear && (cnt_q == PRE);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter draining a FWFT FIFO: start, 8 data bits LSB-first, optional parity, 1 or 2 stops.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 uart_tx_clk_i,
  input  logic                 uart_tx_rst_n_i,
  input  logic                 uart_tx_en_i,
  input  logic [DATA_BITS-1:0] fifo_data_i,
  input  logic                 fifo_empty_i,
  output logic                 fifo_rd_en_o,
  output logic                 uart_tx_o,
  output logic                 uart_tx_busy_o
);

  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

  uart_tx_state_t       state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [2:0]           bit_idx_q;
  logic                 stop_idx_q;
  logic                 parity_q;
  logic                 tx_q;
  logic                 busy_q;
  logic                 rd_en_q;

  logic                 baud_clear;
  logic                 bit_done;
  logic                 bit_pre_done;
  logic                 last_stop;
  logic                 pop_arm_d;
  logic [DATA_BITS-1:0] shift_d;
  logic                 parity_d;

  // Baud counter is parked while idle so every frame starts on a fresh bit period.
  assign baud_clear = (state_q == IDLE);

  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk          (uart_tx_clk_i),
    .rst_n        (uart_tx_rst_n_i),
    .clear        (baud_clear),
    .bit_done     (bit_done),
    .bit_pre_done (bit_pre_done)
  );

  // Pop is armed one cycle early so the registered strobe lands on the capture cycle.
  assign last_stop = (state_q == STOP) && (stop_idx_q == LAST_STOP);
  assign pop_arm_d = uart_tx_en_i && !fifo_empty_i && !rd_en_q &&
                     ((state_q == IDLE) || (last_stop && bit_pre_done));

  // FWFT head is valid while the strobe is high; capture it with its parity.
  assign shift_d  = fifo_data_i;
  assign parity_d = parity_bit(fifo_data_i, 1'(PARITY_ODD));

  // Frame sequencer with registered line, busy and pop outputs.
  always_ff @(posedge uart_tx_clk_i or negedge uart_tx_rst_n_i) begin
    if (!uart_tx_rst_n_i) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      rd_en_q    <= 1'b0;
    end else begin
      rd_en_q <= pop_arm_d;
      case (state_q)
        IDLE: begin
          if (rd_en_q) begin
            shift_q  <= shift_d;
            parity_q <= parity_d;
            tx_q     <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= START;
          end
        end
        START: begin
          if (bit_done) begin
            tx_q      <= shift_q[0];
            bit_idx_q <= '0;
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (bit_done) begin
            shift_q <= shift_q >> 1;
            if (bit_idx_q == LAST_BIT) begin
              bit_idx_q <= '0;
              if (PARITY_EN != 0) begin
                tx_q    <= parity_q;
                state_q <= PARITY;
              end else begin
                tx_q       <= 1'b1;
                stop_idx_q <= 1'b0;
                state_q    <= STOP;
              end
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shift_q[1];
            end
          end
        end
        PARITY: begin
          if (bit_done) begin
            tx_q       <= 1'b1;
            stop_idx_q <= 1'b0;
            state_q    <= STOP;
          end
        end
        STOP: begin
          if (bit_done) begin
            if (!last_stop) begin
              stop_idx_q <= stop_idx_q + 1'b1;
            end else if (rd_en_q) begin
              shift_q    <= shift_d;
              parity_q   <= parity_d;
              tx_q       <= 1'b0;
              stop_idx_q <= 1'b0;
              state_q    <= START;
            end else begin
              stop_idx_q <= 1'b0;
              busy_q     <= 1'b0;
              state_q    <= IDLE;
            end
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign fifo_rd_en_o   = rd_en_q;
  assign uart_tx_o      = tx_q;
  assign uart_tx_busy_o = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances cover no-parity, even, odd and two-stop framings.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] en = 4'b0000;
  logic [3:0] rd_w;
  logic [3:0] tx_w;
  logic [3:0] busy_w;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_empty = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         n_pops = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
    .uart_tx_clk_i(clk), .uart_tx_rst_n_i(rst_n), .uart_tx_en_i(en[0]),
    .fifo_data_i(fifo_data), .fifo_empty_i(fifo_empty), .fifo_rd_en_o(rd_w[0]),
    .uart_tx_o(tx_w[0]), .uart_tx_busy_o(busy_w[0]));
  uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut1 (
    .uart_tx_clk_i(clk), .uart_tx_rst_n_i(rst_n), .uart_tx_en_i(en[1]),
    .fifo_data_i(fifo_data), .fifo_empty_i(fifo_empty), .fifo_rd_en_o(rd_w[1]),
    .uart_tx_o(tx_w[1]), .uart_tx_busy_o(busy_w[1]));
  uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut2 (
    .uart_tx_clk_i(clk), .uart_tx_rst_n_i(rst_n), .uart_tx_en_i(en[2]),
    .fifo_data_i(fifo_data), .fifo_empty_i(fifo_empty), .fifo_rd_en_o(rd_w[2]),
    .uart_tx_o(tx_w[2]), .uart_tx_busy_o(busy_w[2]));
  uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_dut3 (
    .uart_tx_clk_i(clk), .uart_tx_rst_n_i(rst_n), .uart_tx_en_i(en[3]),
    .fifo_data_i(fifo_data), .fifo_empty_i(fifo_empty), .fifo_rd_en_o(rd_w[3]),
    .uart_tx_o(tx_w[3]), .uart_tx_busy_o(busy_w[3]));

  // FWFT FIFO model shared by all instances; only one instance is enabled at a time.
  always @(posedge clk) begin
    if ((|rd_w) && (q.size() > 0)) begin
      void'(q.pop_front());
    end
    if (|rd_w) n_pops++;
    if (wr_en) q.push_back(wr_data);
    fifo_empty <= (q.size() == 0);
    fifo_data  <= (q.size() > 0) ? q[0] : 8'h00;
  end

  // Expected line waveform, one entry per clock, CLKS_PER_BIT = 4; idle-high past the frame.
  function automatic logic [63:0] exp_wave(input logic [7:0] b, input int pe, input int po, input int sb);
    logic [63:0] w;
    int          len;
    int          bi;
    w   = '1;
    len = (10 + pe + sb - 1) * 4;
    for (int c = 0; c < len; c++) begin
      bi = c / 4;
      if (bi == 0)                   w[c] = 1'b0;
      else if (bi <= 8)              w[c] = b[bi-1];
      else if ((pe != 0) && bi == 9) w[c] = (^b) ^ po[0];
      else                           w[c] = 1'b1;
    end
    return w;
  endfunction

  function automatic logic [63:0] mask(input int len);
    return (64'h1 << len) - 64'h1;
  endfunction

  task automatic push(input logic [7:0] b);
    wr_data = b;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // Returns at the negedge inside the pop cycle of instance k (bounded).
  task automatic wait_pop(input int k, input string name);
    int cyc;
    cyc = 0;
    while ((rd_w[k] !== 1'b1) && (cyc < 200)) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (rd_w[k] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: pop wait timed out, rd_en=%b required 1", name, rd_w[k]);
    end
  endtask

  task automatic sample(input int k, input int n, output logic [63:0] tx_v,
                        output logic [63:0] busy_v, output logic [63:0] rd_v);
    tx_v = '1; busy_v = '0; rd_v = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tx_v[i]   = tx_w[k];
      busy_v[i] = busy_w[k];
      rd_v[i]   = rd_w[k];
    end
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #2;
    n_checks++;
    if ({tx_w, busy_w, rd_w} !== 12'hF00) begin
      n_fail++;
      $display("FAIL reset_values: tx/busy/rd=%h required f00", {tx_w, busy_w, rd_w});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({tx_w, busy_w, rd_w} !== 12'hF00) begin
      n_fail++;
      $display("FAIL post_reset_idle: tx/busy/rd=%h required f00", {tx_w, busy_w, rd_w});
    end
  endtask

  task automatic test_single_frame;
    logic [63:0] tx_v, busy_v, rd_v;
    logic [9:0]  pat;
    int          p0;
    pat = 10'b1011001000;
    push(8'h64);
    p0 = n_pops;
    en[0] = 1'b1;
    wait_pop(0, "single_pop");
    n_checks++;
    if ({tx_w[0], busy_w[0]} !== 2'b10) begin
      n_fail++;
      $display("FAIL single_pop_cycle: tx,busy=%b required 10", {tx_w[0], busy_w[0]});
    end
    sample(0, 40, tx_v, busy_v, rd_v);
    for (int c = 0; c < 40; c++) begin
      n_checks++;
      if (tx_v[c] !== pat[c/4]) begin
        n_fail++;
        $display("FAIL single_line cycle %0d: tx=%b required %b", c, tx_v[c], pat[c/4]);
      end
    end
    n_checks++;
    if (busy_v !== mask(40)) begin
      n_fail++;
      $display("FAIL single_busy: busy=%h required %h", busy_v, mask(40));
    end
    n_checks++;
    if (rd_v !== 64'h0) begin
      n_fail++;
      $display("FAIL single_rd_width: rd=%h required 0", rd_v);
    end
    @(negedge clk);
    n_checks++;
    if ({tx_w[0], busy_w[0], rd_w[0]} !== 3'b100 || (n_pops - p0) != 1) begin
      n_fail++;
      $display("FAIL single_end: tx,busy,rd=%b pops=%0d required 100 pops=1",
               {tx_w[0], busy_w[0], rd_w[0]}, n_pops - p0);
    end
    en[0] = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [63:0] tx_v, busy_v, rd_v;
    logic [7:0]  bytes [3];
    int          p0;
    bytes[0] = 8'hA5; bytes[1] = 8'h3C; bytes[2] = 8'hFF;
    push(8'hA5); push(8'h3C); push(8'hFF);
    p0 = n_pops;
    en[0] = 1'b1;
    wait_pop(0, "b2b_pop");
    for (int f = 0; f < 3; f++) begin
      sample(0, 40, tx_v, busy_v, rd_v);
      n_checks++;
      if ((tx_v & mask(40)) !== (exp_wave(bytes[f], 0, 0, 1) & mask(40))) begin
        n_fail++;
        $display("FAIL b2b_line frame %0d: tx=%h required %h", f, tx_v & mask(40),
                 exp_wave(bytes[f], 0, 0, 1) & mask(40));
      end
      n_checks++;
      if (busy_v !== mask(40)) begin
        n_fail++;
        $display("FAIL b2b_busy frame %0d: busy=%h required %h", f, busy_v, mask(40));
      end
      n_checks++;
      if (rd_v !== ((f < 2) ? (64'h1 << 39) : 64'h0)) begin
        n_fail++;
        $display("FAIL b2b_pop_timing frame %0d: rd=%h required %h", f, rd_v,
                 (f < 2) ? (64'h1 << 39) : 64'h0);
      end
    end
    @(negedge clk);
    n_checks++;
    if ({tx_w[0], busy_w[0]} !== 2'b10 || (n_pops - p0) != 3) begin
      n_fail++;
      $display("FAIL b2b_end: tx,busy=%b pops=%0d required 10 pops=3",
               {tx_w[0], busy_w[0]}, n_pops - p0);
    end
    en[0] = 1'b0;
  endtask

  task automatic test_parity(input int k, input int odd, input logic par);
    logic [63:0] tx_v, busy_v, rd_v;
    push(8'h07);
    en[k] = 1'b1;
    wait_pop(k, "parity_pop");
    sample(k, 44, tx_v, busy_v, rd_v);
    n_checks++;
    if (tx_v[37] !== par) begin
      n_fail++;
      $display("FAIL parity_bit odd=%0d: tx=%b required %b", odd, tx_v[37], par);
    end
    n_checks++;
    if ((tx_v & mask(44)) !== (exp_wave(8'h07, 1, odd, 1) & mask(44)) || busy_v !== mask(44)) begin
      n_fail++;
      $display("FAIL parity_frame odd=%0d: tx=%h busy=%h required %h %h", odd, tx_v & mask(44),
               busy_v, exp_wave(8'h07, 1, odd, 1) & mask(44), mask(44));
    end
    @(negedge clk);
    n_checks++;
    if ({tx_w[k], busy_w[k]} !== 2'b10) begin
      n_fail++;
      $display("FAIL parity_end odd=%0d: tx,busy=%b required 10", odd, {tx_w[k], busy_w[k]});
    end
    en[k] = 1'b0;
  endtask

  task automatic test_two_stop;
    logic [63:0] tx_v, busy_v, rd_v;
    push(8'h00);
    en[3] = 1'b1;
    wait_pop(3, "stop2_pop");
    sample(3, 44, tx_v, busy_v, rd_v);
    n_checks++;
    if (tx_v[43:36] !== 8'hFF || tx_v[35:0] !== 36'h0) begin
      n_fail++;
      $display("FAIL stop2_line: tx=%h required 0ff000000000", tx_v & mask(44));
    end
    n_checks++;
    if (busy_v !== mask(44)) begin
      n_fail++;
      $display("FAIL stop2_busy: busy=%h required %h", busy_v, mask(44));
    end
    @(negedge clk);
    n_checks++;
    if ({tx_w[3], busy_w[3]} !== 2'b10) begin
      n_fail++;
      $display("FAIL stop2_end: tx,busy=%b required 10", {tx_w[3], busy_w[3]});
    end
    en[3] = 1'b0;
  endtask

  task automatic test_enable_drop;
    logic [63:0] tx_v, busy_v, rd_v;
    logic [63:0] tx2, busy2, rd2;
    logic [63:0] ew;
    push(8'h5A); push(8'hC3);
    en[0] = 1'b1;
    wait_pop(0, "endrop_pop");
    sample(0, 12, tx_v, busy_v, rd_v);
    en[0] = 1'b0;
    sample(0, 28, tx2, busy2, rd2);
    ew = exp_wave(8'h5A, 0, 0, 1);
    n_checks++;
    if ((tx_v & mask(12)) !== (ew & mask(12)) || (tx2 & mask(28)) !== ((ew >> 12) & mask(28))) begin
      n_fail++;
      $display("FAIL endrop_frame: tx=%h/%h required %h/%h", tx_v & mask(12), tx2 & mask(28),
               ew & mask(12), (ew >> 12) & mask(28));
    end
    n_checks++;
    if ((rd_v | rd2) !== 64'h0) begin
      n_fail++;
      $display("FAIL endrop_no_pop: rd=%h required 0", rd_v | rd2);
    end
    sample(0, 12, tx_v, busy_v, rd_v);
    n_checks++;
    if (tx_v !== '1 || busy_v !== 64'h0 || rd_v !== 64'h0 || fifo_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL endrop_idle: tx=%h busy=%h rd=%h empty=%b required all-1/0/0/0",
               tx_v, busy_v, rd_v, fifo_empty);
    end
    en[0] = 1'b1;
    wait_pop(0, "endrop_drain_pop");
    sample(0, 40, tx_v, busy_v, rd_v);
    en[0] = 1'b0;
    n_checks++;
    if ((tx_v & mask(40)) !== (exp_wave(8'hC3, 0, 0, 1) & mask(40))) begin
      n_fail++;
      $display("FAIL endrop_drain: tx=%h required %h", tx_v & mask(40),
               exp_wave(8'hC3, 0, 0, 1) & mask(40));
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame;
    logic [63:0] tx_v, busy_v, rd_v;
    push(8'h55);
    en[0] = 1'b1;
    wait_pop(0, "rstmid_pop");
    sample(0, 10, tx_v, busy_v, rd_v);
    n_checks++;
    if ((tx_v & mask(10)) !== (exp_wave(8'h55, 0, 0, 1) & mask(10))) begin
      n_fail++;
      $display("FAIL rstmid_prefix: tx=%h required %h", tx_v & mask(10),
               exp_wave(8'h55, 0, 0, 1) & mask(10));
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({tx_w[0], busy_w[0], rd_w[0]} !== 3'b100) begin
      n_fail++;
      $display("FAIL rstmid_async: tx,busy,rd=%b required 100", {tx_w[0], busy_w[0], rd_w[0]});
    end
    push(8'h3C);
    sample(0, 4, tx_v, busy_v, rd_v);
    n_checks++;
    if (rd_v !== 64'h0 || tx_v !== '1) begin
      n_fail++;
      $display("FAIL rstmid_hold: rd=%h tx=%h required 0 and all-1", rd_v, tx_v);
    end
    en[0] = 1'b0;
    rst_n = 1'b1;
    sample(0, 8, tx_v, busy_v, rd_v);
    n_checks++;
    if (rd_v !== 64'h0 || tx_v !== '1 || busy_v !== 64'h0) begin
      n_fail++;
      $display("FAIL rstmid_no_pop_disabled: rd=%h tx=%h busy=%h required 0/all-1/0",
               rd_v, tx_v, busy_v);
    end
    en[0] = 1'b1;
    wait_pop(0, "rstmid_resume_pop");
    sample(0, 40, tx_v, busy_v, rd_v);
    en[0] = 1'b0;
    n_checks++;
    if ((tx_v & mask(40)) !== (exp_wave(8'h3C, 0, 0, 1) & mask(40))) begin
      n_fail++;
      $display("FAIL rstmid_resume: tx=%h required %h", tx_v & mask(40),
               exp_wave(8'h3C, 0, 0, 1) & mask(40));
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_parity(1, 0, 1'b1);
    test_parity(2, 1, 1'b0);
    test_two_stop();
    test_enable_drop();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
